// File: rtl/tm_clause_feedback_sched_pkg.sv
// Shared feedback-type codes, scheduler FSM states and helpers for the clause feedback scheduler.
package tm_pkg;

    localparam logic [1:0] FB_NONE    = 2'b00;
    localparam logic [1:0] FB_TYPE_I  = 2'b01;
    localparam logic [1:0] FB_TYPE_II = 2'b10;
    localparam logic [1:0] FB_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } sched_state_t;

    // Reserved code behaves like FB_NONE: the pass completes without strobes.
    function automatic logic fb_is_active(input logic [1:0] fb_type);
        return (fb_type == FB_TYPE_I) || (fb_type == FB_TYPE_II);
    endfunction

endpackage

// File: rtl/tm_clause_feedback_sched_rule.sv
// Per-automaton Type I / Type II feedback decision; purely combinational.
module tm_feedback_rule
    import tm_pkg::*;
(
    input  logic [1:0] i_fb_type,
    input  logic       i_clause_out,
    input  logic       i_literal,
    input  logic       i_ta_include,
    input  logic       i_rnd_hi,
    input  logic       i_rnd_lo,
    output logic       o_pos_fb,
    output logic       o_neg_fb
);

    always_comb begin
        o_pos_fb = 1'b0;
        o_neg_fb = 1'b0;
        case (i_fb_type)
            FB_TYPE_I: begin
                // Clause fired on a true literal: push toward include with high probability.
                if (i_clause_out && i_literal) begin
                    if (i_ta_include) o_pos_fb = i_rnd_hi;
                    else              o_neg_fb = i_rnd_hi;
                end else begin
                    if (i_ta_include) o_neg_fb = i_rnd_lo;
                    else              o_pos_fb = i_rnd_lo;
                end
            end
            FB_TYPE_II: begin
                o_neg_fb = i_clause_out & ~i_literal & ~i_ta_include;
            end
            default: begin
                o_pos_fb = 1'b0;
                o_neg_fb = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tm_clause_feedback_sched.sv
// Walks the clause's automata one per cycle, issuing Type I / Type II strobes to the addressed TA.
module tm_clause_feedback_sched
    import tm_pkg::*;
#(
    parameter int N_LIT = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       fb_type,
    input  logic             clause_out,
    input  logic [N_LIT-1:0] literals,
    input  logic             rnd_hi,
    input  logic             rnd_lo,
    input  logic             abort,
    input  logic             ta_include,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] ta_sel,
    output logic             ta_pos_fb,
    output logic             ta_neg_fb,
    output logic [CNT_W-1:0] fb_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIT - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    logic [1:0]       r_fb_type;
    logic             r_clause_out;
    logic [N_LIT-1:0] r_literals;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_accept_active;
    logic             w_last;
    logic             w_rule_pos;
    logic             w_rule_neg;
    logic             w_pos;
    logic             w_neg;
    logic             w_literal;

    assign w_literal = r_literals[r_idx];
    assign w_last    = (r_idx == LAST_IDX);

    tm_feedback_rule u_rule (
        .i_fb_type    (r_fb_type),
        .i_clause_out (r_clause_out),
        .i_literal    (w_literal),
        .i_ta_include (ta_include),
        .i_rnd_hi     (rnd_hi),
        .i_rnd_lo     (rnd_lo),
        .o_pos_fb     (w_rule_pos),
        .o_neg_fb     (w_rule_neg)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_accept_active = 1'b0;
        w_pos           = 1'b0;
        w_neg           = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (fb_is_active(fb_type)) begin
                        w_accept_active = 1'b1;
                        w_state_nxt     = S_SCAN;
                    end else begin
                        w_state_nxt     = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                // Abort takes priority over the last index and suppresses this cycle's strobe.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pos = w_rule_pos;
                    w_neg = w_rule_neg;
                    if (w_last) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fb_type    <= FB_NONE;
            r_clause_out <= 1'b0;
            r_literals   <= '0;
            r_idx        <= '0;
            r_count      <= '0;
        end else begin
            if (w_accept) begin
                r_idx   <= '0;
                r_count <= '0;
            end
            if (w_accept_active) begin
                r_fb_type    <= fb_type;
                r_clause_out <= clause_out;
                r_literals   <= literals;
            end
            if (r_state == S_SCAN) begin
                if (w_pos || w_neg) r_count <= r_count + CNT_W'(1);
                if (abort || w_last) r_idx <= '0;
                else                 r_idx <= r_idx + IDX_W'(1);
            end
            if (r_state == S_DONE) r_idx <= '0;
        end
    end

    assign ta_sel    = r_idx;
    assign ta_pos_fb = w_pos;
    assign ta_neg_fb = w_neg;
    assign fb_count  = r_count;

endmodule

// File: tb/tb_tm_clause_feedback_sched.sv
// Directed bench for tm_clause_feedback_sched: per-cycle model comparison plus hand-computed pass results.
module tb_tm_clause_feedback_sched;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst, start, clause_out, rnd_hi, rnd_lo, abort, ta_include;
    logic [1:0] fb_type;
    logic [7:0] literals;
    logic       busy, done, ta_pos_fb, ta_neg_fb;
    logic [2:0] ta_sel;
    logic [3:0] fb_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tm_clause_feedback_sched #(.N_LIT(8), .IDX_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .fb_type(fb_type), .clause_out(clause_out),
        .literals(literals), .rnd_hi(rnd_hi), .rnd_lo(rnd_lo), .abort(abort),
        .ta_include(ta_include), .busy(busy), .done(done), .ta_sel(ta_sel),
        .ta_pos_fb(ta_pos_fb), .ta_neg_fb(ta_neg_fb), .fb_count(fb_count)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // +1 reward, -1 penalty, 0 nothing
    function automatic int exp_fb(input int t, input bit c, input bit l, input bit inc,
                                  input bit hi, input bit lo);
        if (t == 1) begin
            if (c && l) return hi ? (inc ? 1 : -1) : 0;
            return lo ? (inc ? -1 : 1) : 0;
        end
        if (t == 2 && c && !l && !inc) return -1;
        return 0;
    endfunction

    // Model: mode 0 idle, 1 scanning TA m_pos, 2 done cycle
    int       m_mode = 0;
    int       m_pos = 0;
    int       m_type = 0;
    bit       m_c = 0;
    bit [7:0] m_l = '0;
    int       m_cnt = 0;
    bit       m_valid = 0;

    always @(posedge clk) begin
        int f;
        if (!rst) begin
            m_mode = 0; m_pos = 0; m_type = 0; m_c = 0; m_l = '0; m_cnt = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                if (start) begin
                    m_cnt = 0;
                    if (fb_type == 2'b01 || fb_type == 2'b10) begin
                        m_type = int'(fb_type); m_c = clause_out; m_l = literals;
                        m_pos = 0; m_mode = 1;
                    end else begin
                        m_mode = 2;
                    end
                end
            end else if (m_mode == 1) begin
                f = exp_fb(m_type, m_c, m_l[m_pos], ta_include, rnd_hi, rnd_lo);
                if (abort) begin
                    m_mode = 0; m_pos = 0;
                end else begin
                    if (f != 0) m_cnt++;
                    if (m_pos == N - 1) begin m_mode = 2; m_pos = 0; end
                    else m_pos++;
                end
            end else begin
                m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        int  f;
        bit  scan;
        if (m_valid) begin
            scan = (m_mode == 1);
            f = scan ? exp_fb(m_type, m_c, m_l[m_pos], ta_include, rnd_hi, rnd_lo) : 0;
            if (abort) f = 0;
            check("busy",      int'(busy),      int'(m_mode != 0));
            check("done",      int'(done),      int'(m_mode == 2));
            check("ta_sel",    int'(ta_sel),    scan ? m_pos : 0);
            check("ta_pos_fb", int'(ta_pos_fb), int'(f == 1));
            check("ta_neg_fb", int'(ta_neg_fb), int'(f == -1));
            check("fb_count",  int'(fb_count),  m_cnt);
        end
    end

    int       r_done, r_busy, r_sel;
    logic [7:0] r_pm, r_nm;

    task automatic run_pass(input logic [1:0] t, input logic c, input logic [7:0] lits,
                            input logic hi, input logic lo, input logic inc, input bit rnd_mode,
                            input int abort_cyc, input int mid_start_cyc, input int rst_cyc);
        r_done = -1; r_busy = 0; r_sel = -1; r_pm = '0; r_nm = '0;
        fb_type = t; clause_out = c; literals = lits;
        rnd_hi = hi; rnd_lo = lo; ta_include = inc; abort = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            abort = (cyc == abort_cyc);
            start = (cyc == mid_start_cyc);
            rst   = !(cyc == rst_cyc);
            if (rnd_mode) begin
                rnd_hi = 1'($urandom_range(0, 1));
                rnd_lo = 1'($urandom_range(0, 1));
                ta_include = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (busy) r_busy++;
            if (done && r_done < 0) r_done = cyc;
            if (ta_pos_fb) r_pm[ta_sel] = 1'b1;
            if (ta_neg_fb) r_nm[ta_sel] = 1'b1;
            if (ta_pos_fb || ta_neg_fb) r_sel = int'(ta_sel);
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; fb_type = 2'b00; clause_out = 1'b0; literals = '0;
        rnd_hi = 1'b0; rnd_lo = 1'b0; abort = 1'b0; ta_include = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; fb_type = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobes", int'(ta_pos_fb | ta_neg_fb), 0);
        check("rst_fb_count", int'(fb_count), 0);
        check("rst_ta_sel", int'(ta_sel), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Type I, C=1, all literals true, TA excluded: penalties everywhere
        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("t1_done_cyc", r_done, 9);
        check("t1_neg_mask", int'(r_nm), 8'hFF);
        check("t1_pos_mask", int'(r_pm), 0);
        check("t1_last_sel", r_sel, 7);
        check("t1_busy_cyc", r_busy, 9);
        check("t1_fb_count", int'(fb_count), 8);

        run_pass(2'b01, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
        check("t2_neg_mask", int'(r_nm), 8'hFF);
        check("t2_fb_count", int'(fb_count), 8);

        run_pass(2'b01, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        check("t3_strobes", int'(r_nm | r_pm), 0);
        check("t3_fb_count", int'(fb_count), 0);
        check("t3_done_cyc", r_done, 9);

        run_pass(2'b10, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check("t4_neg_mask", int'(r_nm), 8'hF0);
        check("t4_pos_mask", int'(r_pm), 0);
        check("t4_fb_count", int'(fb_count), 4);

        // fb_type none: done next cycle; abort during DONE is ignored
        run_pass(2'b00, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0);
        check("t5_done_cyc", r_done, 1);
        check("t5_busy_cyc", r_busy, 1);
        check("t5_strobes", int'(r_nm | r_pm), 0);
        check("t5_fb_count", int'(fb_count), 0);

        run_pass(2'b11, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check("t6_done_cyc", r_done, 1);
        check("t6_strobes", int'(r_nm | r_pm), 0);

        // abort at ta_sel 3 with an ignored mid-pass start
        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 4, 2, 0);
        check("t7_done_cyc", r_done, -1);
        check("t7_neg_mask", int'(r_nm), 8'h07);
        check("t7_busy_cyc", r_busy, 4);
        check("t7_fb_count", int'(fb_count), 3);

        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("t8_done_cyc", r_done, 9);
        check("t8_fb_count", int'(fb_count), 8);

        // abort coincides with the last index
        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 8, 0, 0);
        check("t9_done_cyc", r_done, -1);
        check("t9_neg_mask", int'(r_nm), 8'h7F);
        check("t9_fb_count", int'(fb_count), 7);

        run_pass(2'b01, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check("t10_neg_mask", int'(r_nm), 8'h0F);
        check("t10_pos_mask", int'(r_pm), 8'hF0);

        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        check("t11_pos_mask", int'(r_pm), 8'hFF);

        // reset low during cycle 3: strobes stop, no done, count cleared
        run_pass(2'b01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3);
        check("t12_neg_mask", int'(r_nm), 8'h07);
        check("t12_done_cyc", r_done, -1);
        check("t12_busy_cyc", r_busy, 3);
        check("t12_fb_count", int'(fb_count), 0);

        run_pass(2'b01, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
        check("t13_done_cyc", r_done, 9);
        run_pass(2'b10, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
        check("t14_done_cyc", r_done, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
